sifh_zoom_controller: RTL and testbench

//  Sequences the multi-stage coarse-to-fine SiFH histogram. Per stage: clear the histogram,

---
 rtl/sifh_zoom_controller.sv | 132 +++++++++++++
 tb/tb_sifh_zoom_controller.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sifh_zoom_controller.sv
// rtl/sifh_zoom_controller.sv - coarse-to-fine SiFH histogram zoom sequencer
// Each stage clears, accumulates N_FRAMES frames, asks for the peak and narrows the window around it.
module sifh_zoom_controller #(
  parameter int NB       = 4,
  parameter int NP       = 12,
  parameter int N_STAGES = 3,
  parameter int N_FRAMES = 1000,
  parameter int TIMEOUT  = 255,
  localparam int SW      = $clog2(NP),
  localparam int STW     = $clog2(N_STAGES) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          laser_sync,
  input  logic          peak_ready,
  input  logic [NB-1:0] peak_ch,
  input  logic          peak_empty,
  output logic          hist_clr,
  output logic          hist_en,
  output logic          peak_req,
  output logic [NP-1:0] win_lo,
  output logic [SW-1:0] bin_shift,
  output logic [STW-1:0] stage,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [NP-1:0] result
);

  localparam int AW = NP + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_PREQ, S_PWAIT, S_UPDATE, S_DONE
  } state_t;

  state_t        st, nxt;
  logic [15:0]   frame_cnt;
  logic [7:0]    to_cnt;
  logic [NB-1:0] peak_q;
  logic          last_stage, frames_done, timed_out;
  logic [AW-1:0] w, ctr, lo, lim;
  logic [NP-1:0] win_lo_nxt;

  assign last_stage  = (stage == STW'(N_STAGES - 1));
  assign frames_done = laser_sync && (frame_cnt == 16'(N_FRAMES - 1));
  assign timed_out   = (to_cnt == 8'(TIMEOUT - 1));

  // Centre of the peak bin, then a two-bin window starting one bin below it, kept inside the code range.
  assign w   = AW'(1) << bin_shift;
  assign ctr = AW'(win_lo) + (AW'(peak_q) << bin_shift) + (w >> 1);
  assign lo  = ctr - w;
  assign lim = AW'(1) << NP;
  assign win_lo_nxt = (ctr < w) ? '0 :
                      ((lo + (w << 1)) > lim) ? NP'(lim - (w << 1)) : NP'(lo);

  always_comb begin
    nxt = st;
    case (st)
      S_IDLE:   if (start) nxt = S_CLEAR;
      S_CLEAR:  nxt = S_ACCUM;
      S_ACCUM:  if (frames_done) nxt = S_PREQ;
      S_PREQ:   nxt = S_PWAIT;
      S_PWAIT: begin
        if (peak_ready)     nxt = peak_empty ? S_DONE : S_UPDATE;
        else if (timed_out) nxt = S_DONE;
      end
      S_UPDATE: nxt = last_stage ? S_DONE : S_CLEAR;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      frame_cnt <= '0;
      to_cnt    <= '0;
      peak_q    <= '0;
      win_lo    <= '0;
      bin_shift <= SW'(NP - NB);
      stage     <= '0;
      err       <= 1'b0;
      result    <= '0;
    end else begin
      st <= nxt;
      // Abort freezes all bookkeeping so err/result survive it untouched.
      if (!abort) begin
        case (st)
          S_IDLE: if (start) begin
            stage     <= '0;
            win_lo    <= '0;
            bin_shift <= SW'(NP - NB);
            err       <= 1'b0;
            result    <= '0;
          end
          S_CLEAR: frame_cnt <= '0;
          S_ACCUM: if (laser_sync) frame_cnt <= frame_cnt + 16'd1;
          S_PREQ:  to_cnt <= '0;
          S_PWAIT: begin
            if (peak_ready) begin
              if (peak_empty) err <= 1'b1;
              else            peak_q <= peak_ch;
            end else begin
              to_cnt <= to_cnt + 8'd1;
              if (timed_out) err <= 1'b1;
            end
          end
          S_UPDATE: begin
            if (last_stage) begin
              result <= NP'(ctr);
            end else begin
              win_lo    <= win_lo_nxt;
              bin_shift <= bin_shift - SW'(NB - 1);
              stage     <= stage + STW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign hist_clr = (st == S_CLEAR);
  assign hist_en  = (st == S_ACCUM);
  assign peak_req = (st == S_PREQ);
  assign busy     = (st != S_IDLE);
  assign done     = (st == S_DONE);

endmodule

// File: tb/tb_sifh_zoom_controller.sv
// tb/tb_sifh_zoom_controller.sv - scoreboard bench for sifh_zoom_controller
module tb_sifh_zoom_controller;

  localparam int NB = 4, NP = 12, N_STAGES = 3, N_FRAMES = 1000, TIMEOUT = 255;

  logic          clk = 0, rst_n = 0, start = 0, abort = 0, laser_sync = 0;
  logic          peak_ready = 0, peak_empty = 0;
  logic [NB-1:0] peak_ch = '0;
  logic          hist_clr, hist_en, peak_req, busy, done, err;
  logic [NP-1:0] win_lo, result;
  logic [3:0]    bin_shift;
  logic [2:0]    stage;

  typedef struct {
    logic [NP-1:0] result;
    logic          err;
    logic [2:0]    stage;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, acc = 0, cyc = 0, t0 = 0;
  bit found;

  sifh_zoom_controller #(
    .NB(NB), .NP(NP), .N_STAGES(N_STAGES), .N_FRAMES(N_FRAMES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .laser_sync(laser_sync),
    .peak_ready(peak_ready), .peak_ch(peak_ch), .peak_empty(peak_empty),
    .hist_clr(hist_clr), .hist_en(hist_en), .peak_req(peak_req), .win_lo(win_lo),
    .bin_shift(bin_shift), .stage(stage), .busy(busy), .done(done), .err(err),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // sel: 0 = peak_req, 1 = done, 2 = hist_en
  task automatic wait_sig(input int sel, input string tag, output bit ok);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      if ((sel == 0 && peak_req) || (sel == 1 && done) || (sel == 2 && hist_en)) begin
        ok = 1;
        break;
      end
      tick();
    end
    chk(tag, ok, 1);
  endtask

  task automatic stage_step(input logic [NP-1:0] ew, input logic [3:0] es, input logic [2:0] est,
                            input logic [NB-1:0] ch, input bit empty, input bit respond);
    bit ok;
    wait_sig(0, "peak_req_seen", ok);
    if (ok) begin
      chk("win_lo", win_lo, ew);
      chk("bin_shift", bin_shift, es);
      chk("stage", stage, est);
      if (respond) begin
        repeat (3) tick();
        peak_ready = 1;
        peak_ch    = ch;
        peak_empty = empty;
        tick();
        peak_ready = 0;
        peak_empty = 0;
      end
    end
  endtask

  // Free-running laser: a 1-cycle pulse every other cycle, also outside ACCUM.
  initial forever begin
    @(posedge clk);
    #1;
    laser_sync = ~laser_sync;
  end

  // Scoreboard side: frames accepted per stage and end-of-measurement results.
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (hist_clr) acc = 0;
    if (hist_en && laser_sync) acc++;
    if (peak_req) chk("frames_per_stage", acc, N_FRAMES);
    if (done) begin
      if (sb.size() == 0) begin
        chk("done_expected", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("done_result", result, e.result);
        chk("done_err", err, e.err);
        chk("done_stage", stage, e.stage);
      end
    end
  end

  initial begin
    repeat (3) tick();
    rst_n = 1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_win_lo", win_lo, 0);
    chk("rst_bin_shift", bin_shift, NP - NB);
    chk("rst_stage", stage, 0);
    chk("rst_strobes", {hist_clr, hist_en, peak_req}, 0);
    tick();

    start = 1; abort = 1;
    tick();
    start = 0; abort = 0;
    chk("start_abort_busy", busy, 0);

    // nominal three-stage run, with a stray start while busy
    sb.push_back('{12'd1438, 1'b0, 3'd2});
    pulse_start();
    wait_sig(2, "t6_hist_en", found);
    repeat (4) tick();
    pulse_start();
    chk("t6_busy", busy, 1);
    chk("t6_stage", stage, 0);
    stage_step(12'd0, 4'd8, 3'd0, 4'd5, 1'b0, 1'b1);
    stage_step(12'd1152, 4'd5, 3'd1, 4'd9, 1'b0, 1'b1);
    stage_step(12'd1424, 4'd2, 3'd2, 4'd3, 1'b0, 1'b1);
    wait_sig(1, "t1_done", found);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_result_held", result, 1438);

    // low and high clamps, each ended by abort in PWAIT
    for (int k = 0; k < 2; k++) begin
      pulse_start();
      stage_step(12'd0, 4'd8, 3'd0, (k == 0) ? 4'd0 : 4'd15, 1'b0, 1'b1);
      stage_step((k == 0) ? 12'd0 : 12'd3584, 4'd5, 3'd1, 4'd0, 1'b0, 1'b0);
      abort = 1;
      tick();
      abort = 0;
      chk("clamp_abort_busy", busy, 0);
      chk("clamp_abort_err", err, 0);
      chk("clamp_abort_result", result, 0);
    end

    // empty histogram at stage 1
    sb.push_back('{12'd0, 1'b1, 3'd1});
    pulse_start();
    stage_step(12'd0, 4'd8, 3'd0, 4'd5, 1'b0, 1'b1);
    stage_step(12'd1152, 4'd5, 3'd1, 4'd0, 1'b1, 1'b1);
    wait_sig(1, "t3_done", found);
    tick();
    chk("t3_err_held", err, 1);
    chk("t3_stage", stage, 1);

    // peak finder never answers
    sb.push_back('{12'd0, 1'b1, 3'd0});
    pulse_start();
    stage_step(12'd0, 4'd8, 3'd0, 4'd0, 1'b0, 1'b0);
    t0 = cyc;
    wait_sig(1, "t4_done", found);
    chk("t4_latency", cyc - t0, TIMEOUT + 1);
    tick();

    // abort mid-ACCUM of stage 1, then a fresh run
    pulse_start();
    stage_step(12'd0, 4'd8, 3'd0, 4'd9, 1'b0, 1'b1);
    wait_sig(2, "t5_hist_en", found);
    repeat (10) tick();
    abort = 1;
    tick();
    abort = 0;
    chk("t5_busy", busy, 0);
    chk("t5_hist_en", hist_en, 0);
    chk("t5_win_lo_kept", win_lo, 2176);
    repeat (5) tick();
    sb.push_back('{12'd0, 1'b1, 3'd0});
    pulse_start();
    stage_step(12'd0, 4'd8, 3'd0, 4'd0, 1'b1, 1'b1);
    wait_sig(1, "t5_done", found);
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
